ps2_scan_receiver: RTL and testbench

PS/2 device-to-host receiver with a scan-code FIFO. It sits directly upstream of the Specialist keyboard matrix decoder and feeds it through the `rx_scan_code` / `rx_data_ready` / `rx_read` handshake. The block does the following:
- synchronises and de-glitches the raw `ps2_clk` / `ps2_data` lines;
- deserialises 11-bit frames;
- validates each frame;
- buffers good bytes, so that bursts such as `E0 F0 xx` arrive intact while the decoder is busy.

---
 rtl/ps2_scan_receiver.sv | 163 ++++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_receiver.sv
// rtl/ps2_scan_receiver.sv - PS/2 device-to-host receiver with scan-code FIFO; optional PS2_PARITY_CHECK_EN
module ps2_scan_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,  // must be at least 2
  parameter int FIFO_AW        = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_scan_code,
  output logic       rx_data_ready,
  input  logic       rx_read,
  output logic       rx_overflow,
  output logic       rx_frame_err
);

  localparam int FCW   = $clog2(FILTER_LEN + 1);
  localparam int TCW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DEPTH = 1 << FIFO_AW;

  logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic             dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic [FCW-1:0]   clk_fcnt_q, clk_fcnt_d, dat_fcnt_q, dat_fcnt_d;
  logic             clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
  logic             clk_prev_q, clk_prev_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic [TCW-1:0]   to_cnt_q, to_cnt_d;
  logic             err_q, err_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       scan_q, scan_d;
  logic [7:0]       mem_q [DEPTH];

  logic fall, frame_ok, push, pop, full, wr_en;

  // Synchronise both raw lines and debounce them with saturating run counters
  always_comb begin
    clk_s1_d   = ps2_clk_i;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data_i;
    dat_s2_d   = dat_s1_q;
    clk_fcnt_d = '0;
    clk_filt_d = clk_filt_q;
    dat_fcnt_d = '0;
    dat_filt_d = dat_filt_q;
    if (clk_s2_q != clk_filt_q) begin
      if (clk_fcnt_q == FCW'(FILTER_LEN - 1)) clk_filt_d = clk_s2_q;
      else                                    clk_fcnt_d = clk_fcnt_q + FCW'(1);
    end
    if (dat_s2_q != dat_filt_q) begin
      if (dat_fcnt_q == FCW'(FILTER_LEN - 1)) dat_filt_d = dat_s2_q;
      else                                    dat_fcnt_d = dat_fcnt_q + FCW'(1);
    end
  end

  // Frame deserialiser, frame check and inter-edge timeout
  always_comb begin
    fall       = clk_prev_q & ~clk_filt_q;
    clk_prev_d = clk_filt_q;
`ifdef PS2_PARITY_CHECK_EN
    frame_ok   = dat_filt_q & (^shift_q);
`else
    frame_ok   = dat_filt_q;
`endif
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    to_cnt_d   = '0;
    push       = 1'b0;
    err_d      = 1'b0;
    if (fall) begin
      // Counter restarts at 1 so that it equals the cycles elapsed since this edge
      to_cnt_d = TCW'(1);
      if (bit_cnt_q == 4'd0) begin
        if (!dat_filt_q) bit_cnt_d = 4'd1;
      end else if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (frame_ok) push  = 1'b1;
        else          err_d = 1'b1;
      end else begin
        shift_d   = {dat_filt_q, shift_q[8:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d = 4'd0;
        err_d     = 1'b1;
      end else begin
        to_cnt_d  = to_cnt_q + TCW'(1);
      end
    end
  end

  // FIFO pointers, occupancy, sticky overflow and the registered pop output
  always_comb begin
    pop      = rx_read && (count_q != '0);
    full     = (count_q == (FIFO_AW + 1)'(DEPTH));
    wr_en    = push && (!full || pop);
    ovf_d    = ovf_q | (push && full && !pop);
    wr_ptr_d = wr_ptr_q + (wr_en ? FIFO_AW'(1) : FIFO_AW'(0));
    rd_ptr_d = rd_ptr_q + (pop ? FIFO_AW'(1) : FIFO_AW'(0));
    count_d  = count_q;
    if (wr_en && !pop)      count_d = count_q + (FIFO_AW + 1)'(1);
    else if (pop && !wr_en) count_d = count_q - (FIFO_AW + 1)'(1);
    scan_d   = pop ? mem_q[rd_ptr_q] : scan_q;
  end

  // State registers; synchronisers and filters idle at the line-high level
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      clk_fcnt_q <= '0;
      dat_fcnt_q <= '0;
      clk_filt_q <= 1'b1;
      dat_filt_q <= 1'b1;
      clk_prev_q <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      scan_q     <= '0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      clk_fcnt_q <= clk_fcnt_d;
      dat_fcnt_q <= dat_fcnt_d;
      clk_filt_q <= clk_filt_d;
      dat_filt_q <= dat_filt_d;
      clk_prev_q <= clk_prev_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      scan_q     <= scan_d;
    end
  end

  // FIFO storage has no reset; contents are only meaningful below count_q
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q[7:0];
  end

  assign rx_scan_code  = scan_q;
  assign rx_data_ready = (count_q != '0);
  assign rx_overflow   = ovf_q;
  assign rx_frame_err  = err_q;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb/tb_ps2_scan_receiver.sv - self-checking bench for ps2_scan_receiver
module tb_ps2_scan_receiver;

  localparam int FILT = 4;
  localparam int TMO  = 200;
  localparam int HALF = 20;
  localparam int LAT  = 2 + FILT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk_i = 1'b1;
  logic       ps2_data_i = 1'b1;
  logic [7:0] rx_scan_code;
  logic       rx_data_ready;
  logic       rx_read = 1'b0;
  logic       rx_overflow;
  logic       rx_frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;

  ps2_scan_receiver #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO), .FIFO_AW(3)) dut (
    .clk(clk), .reset(reset), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .rx_scan_code(rx_scan_code), .rx_data_ready(rx_data_ready), .rx_read(rx_read),
    .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_frame_err === 1'b1) err_cnt++;

  typedef struct {
    logic [7:0] data;
    logic       pflip;
    logic       stop;
    logic       exp_push;
    int         exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic pflip, input logic stop);
    mk = {stop, (~^b) ^ pflip, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data_i = f[i];
      tick(HALF);
      ps2_clk_i = 1'b0;
      tick(HALF);
      ps2_clk_i = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [10:0] f);
    send_bits(f, 11);
    ps2_data_i = 1'b1;
    tick(HALF);
  endtask

  task automatic pop_one();
    rx_read = 1'b1;
    tick(1);
    rx_read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  vec_t vecs[6];
  int   e0, lat;
  logic [10:0] f;

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 0};
`ifdef PS2_PARITY_CHECK_EN
    vecs[1] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1};
`else
    vecs[1] = '{8'h5A, 1'b1, 1'b1, 1'b1, 0};
`endif
    vecs[2] = '{8'h33, 1'b0, 1'b0, 1'b0, 1};
    vecs[3] = '{8'hA5, 1'b0, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b1, 0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 0};

    tick(3);
    reset = 1'b0;
    tick(2);
    check("reset scan_code", rx_scan_code, 8'h00);
    check("reset data_ready", rx_data_ready, 1'b0);
    check("reset overflow", rx_overflow, 1'b0);
    check("reset frame_err", rx_frame_err, 1'b0);

    // good frame with stop-edge latency
    f = mk(8'h1C, 1'b0, 1'b1);
    send_bits(f, 10);
    ps2_data_i = f[10];
    tick(HALF);
    ps2_clk_i = 1'b0;
    lat = -1;
    for (int c = 1; c <= 3 * LAT && lat < 0; c++) begin
      tick(1);
      if (rx_data_ready === 1'b1) lat = c;
    end
    check("good latency", lat, LAT + 1);
    tick(HALF);
    ps2_clk_i = 1'b1;
    tick(HALF);
    pop_one();
    check("good code", rx_scan_code, 8'h1C);
    check("good ready after pop", rx_data_ready, 1'b0);

    // burst without reads
    e0 = err_cnt;
    send_frame(mk(8'hE0, 1'b0, 1'b1));
    send_frame(mk(8'hF0, 1'b0, 1'b1));
    send_frame(mk(8'h75, 1'b0, 1'b1));
    check("burst ready", rx_data_ready, 1'b1);
    pop_one(); check("burst 0", rx_scan_code, 8'hE0);
    tick(1);
    pop_one(); check("burst 1", rx_scan_code, 8'hF0);
    tick(1);
    pop_one(); check("burst 2", rx_scan_code, 8'h75);
    check("burst empty", rx_data_ready, 1'b0);
    check("burst no err", err_cnt - e0, 0);
    check("burst no ovf", rx_overflow, 1'b0);

    // table of single frames
    for (int i = 0; i < 6; i++) begin
      e0 = err_cnt;
      send_frame(mk(vecs[i].data, vecs[i].pflip, vecs[i].stop));
      check($sformatf("vec%0d ready", i), rx_data_ready, vecs[i].exp_push);
      check($sformatf("vec%0d err", i), err_cnt - e0, vecs[i].exp_err);
      if (vecs[i].exp_push) begin
        pop_one();
        check($sformatf("vec%0d code", i), rx_scan_code, vecs[i].data);
      end
    end

    // overflow: 9 pushes, 8 kept
    for (int i = 0; i < 9; i++) begin
      send_frame(mk(8'h10 + 8'(i), 1'b0, 1'b1));
      check($sformatf("ovf flag %0d", i), rx_overflow, (i == 8) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      pop_one();
      check($sformatf("ovf pop %0d", i), rx_scan_code, 8'h10 + 8'(i));
    end
    check("ovf drained", rx_data_ready, 1'b0);
    check("ovf sticky", rx_overflow, 1'b1);

    // push on full with a same-cycle pop
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(mk(8'h20 + 8'(i), 1'b0, 1'b1));
    f = mk(8'h28, 1'b0, 1'b1);
    send_bits(f, 10);
    ps2_data_i = f[10];
    tick(HALF);
    ps2_clk_i = 1'b0;
    tick(LAT);
    rx_read = 1'b1;
    tick(1);
    rx_read = 1'b0;
    check("full+pop code", rx_scan_code, 8'h20);
    tick(HALF);
    ps2_clk_i = 1'b1;
    tick(HALF);
    check("full+pop no ovf", rx_overflow, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      pop_one();
      check($sformatf("full+pop pop %0d", i), rx_scan_code, 8'h20 + 8'(i));
    end
    check("full+pop drained", rx_data_ready, 1'b0);

    // timeout after 4 bits
    e0 = err_cnt;
    f = mk(8'h29, 1'b0, 1'b1);
    send_bits(f, 3);
    ps2_data_i = f[3];
    tick(HALF);
    ps2_clk_i = 1'b0;
    lat = -1;
    for (int c = 1; c <= TMO + 4 * LAT && lat < 0; c++) begin
      tick(1);
      if (rx_frame_err === 1'b1) lat = c;
    end
    check("timeout latency", lat, TMO + LAT);
    tick(1);
    check("timeout pulse width", rx_frame_err, 1'b0);
    ps2_clk_i = 1'b1;
    tick(HALF);
    check("timeout one err", err_cnt - e0, 1);
    check("timeout no push", rx_data_ready, 1'b0);
    e0 = err_cnt;
    send_frame(f);
    pop_one();
    check("after timeout code", rx_scan_code, 8'h29);
    check("after timeout no err", err_cnt - e0, 0);

    // 3-cycle glitch on ps2_clk with data low (would look like a start bit)
    e0 = err_cnt;
    ps2_data_i = 1'b0;
    tick(HALF);
    ps2_clk_i = 1'b0;
    tick(3);
    ps2_clk_i = 1'b1;
    tick(HALF);
    ps2_data_i = 1'b1;
    tick(HALF);
    send_frame(mk(8'h6B, 1'b0, 1'b1));
    check("glitch ready", rx_data_ready, 1'b1);
    pop_one();
    check("glitch code", rx_scan_code, 8'h6B);
    check("glitch no err", err_cnt - e0, 0);

    // reset mid-frame with two entries queued
    send_frame(mk(8'h11, 1'b0, 1'b1));
    send_frame(mk(8'h22, 1'b0, 1'b1));
    pop_one();
    send_frame(mk(8'h33, 1'b0, 1'b1));
    send_bits(mk(8'h44, 1'b0, 1'b1), 5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    check("midreset scan_code", rx_scan_code, 8'h00);
    check("midreset ready", rx_data_ready, 1'b0);
    check("midreset overflow", rx_overflow, 1'b0);
    check("midreset frame_err", rx_frame_err, 1'b0);
    ps2_data_i = 1'b1;
    tick(HALF);
    send_frame(mk(8'h4D, 1'b0, 1'b1));
    pop_one();
    check("post reset code", rx_scan_code, 8'h4D);
    check("post reset empty", rx_data_ready, 1'b0);

    // read while empty
    pop_one();
    check("empty read code", rx_scan_code, 8'h4D);
    check("empty read ready", rx_data_ready, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
